// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage sequencer for an RV32I pipeline: arbitrates E-stage redirects, load-use
// hazards and instruction-memory wait states, and keeps saturating perf counters.
module fetch_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             JalE,
    input  logic             JalrE,
    input  logic             Branch_resultE,
    input  logic [31:0]      ALU_ResultE,
    input  logic             MemReadE,
    input  logic [4:0]       RdE,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic             Rs1UsedD,
    input  logic             Rs2UsedD,
    input  logic             imem_ready,
    output logic             PCSel,
    output logic [31:0]      PCTarget,
    output logic             PCEn,
    output logic             IFIDEn,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_WAIT, S_FLUSH} state_t;

    state_t           state_q;
    logic [FW-1:0]    fcnt_q;
    logic [CNT_W-1:0] redirCnt_q, redirCnt_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic             misalign_q;

    logic redir;
    logic lu;
    logic redirTaken;
    logic stallCycle;

    assign redir = JalE | JalrE | Branch_resultE;
    assign lu    = MemReadE && (RdE != 5'd0) &&
                   ((Rs1UsedD && (Rs1D == RdE)) || (Rs2UsedD && (Rs2D == RdE)));

    assign PCTarget = {ALU_ResultE[31:1], ALU_ResultE[0] & ~JalrE};

    // Counters stick at all-ones instead of wrapping.
    assign redirCnt_d = (redirCnt_q == '1) ? redirCnt_q : redirCnt_q + CNT_W'(1);
    assign stallCnt_d = (stallCnt_q == '1) ? stallCnt_q : stallCnt_q + CNT_W'(1);

    assign misalign_err = misalign_q;
    assign redirect_cnt = redirCnt_q;
    assign stall_cnt    = stallCnt_q;

    always_comb begin
        PCSel      = 1'b0;
        PCEn       = 1'b0;
        IFIDEn     = 1'b0;
        IFIDFlush  = 1'b1;
        IDEXFlush  = 1'b1;
        redirTaken = 1'b0;
        stallCycle = 1'b0;
        if (!rst && state_q != S_HOLD) begin
            if (redir) begin
                PCSel      = 1'b1;
                PCEn       = 1'b1;
                redirTaken = 1'b1;
            end else if (state_q == S_FLUSH) begin
                PCEn      = imem_ready;
                IDEXFlush = 1'b0;
            end else if (state_q == S_WAIT) begin
                // D already holds a NOP here; a hazard only needs the extra bubble into E.
                PCEn       = imem_ready;
                IFIDEn     = imem_ready;
                IFIDFlush  = ~imem_ready;
                IDEXFlush  = lu;
                stallCycle = ~imem_ready;
            end else if (lu) begin
                IFIDFlush  = 1'b0;
                stallCycle = 1'b1;
            end else if (!imem_ready) begin
                IDEXFlush  = 1'b0;
                stallCycle = 1'b1;
            end else begin
                PCEn      = 1'b1;
                IFIDEn    = 1'b1;
                IFIDFlush = 1'b0;
                IDEXFlush = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HOLD;
            fcnt_q     <= '0;
            redirCnt_q <= '0;
            stallCnt_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            if (redirTaken) begin
                if (FLUSH_CYCLES > 1) begin
                    state_q <= S_FLUSH;
                    fcnt_q  <= FW'(FLUSH_CYCLES - 1);
                end else begin
                    state_q <= S_RUN;
                    fcnt_q  <= '0;
                end
                redirCnt_q <= redirCnt_d;
                if (PCTarget[1:0] != 2'b00) begin
                    misalign_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    S_HOLD:  state_q <= S_RUN;
                    S_RUN:   if (!lu && !imem_ready) state_q <= S_WAIT;
                    S_WAIT:  if (imem_ready) state_q <= S_RUN;
                    S_FLUSH: begin
                        // Only cycles that actually fetched count toward the flush window.
                        if (imem_ready) begin
                            fcnt_q <= fcnt_q - FW'(1);
                            if (fcnt_q <= FW'(1)) state_q <= S_RUN;
                        end
                    end
                endcase
            end
            if (stallCycle) begin
                stallCnt_q <= stallCnt_d;
            end
        end
    end

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Self-checking bench for fetch_hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_fetch_hazard_ctrl;

    localparam int FC     = 2;
    localparam int TB_CNT = 6;
    localparam int CMAX   = (1 << TB_CNT) - 1;

    logic              clk = 1'b0;
    logic              rst, JalE, JalrE, Branch_resultE, MemReadE;
    logic [31:0]       ALU_ResultE;
    logic [4:0]        RdE, Rs1D, Rs2D;
    logic              Rs1UsedD, Rs2UsedD, imem_ready;
    logic              PCSel, PCEn, IFIDEn, IFIDFlush, IDEXFlush, misalign_err;
    logic [31:0]       PCTarget;
    logic [TB_CNT-1:0] redirect_cnt, stall_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: cycles of hold left, extra flush fetches left, waiting on imem.
    int  holdLeft = 1;
    int  flushLeft = 0;
    bit  waiting = 0;
    int  redirCount = 0;
    int  stallCount = 0;
    bit  misalign = 0;
    bit  modelKnown = 0;
    bit  expSel, expEn, expIfEn, expIfFl, expIdFl, tookRedir, stalled;
    logic [31:0] expTarget;

    fetch_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(TB_CNT)) dut (
        .clk(clk), .rst(rst), .JalE(JalE), .JalrE(JalrE), .Branch_resultE(Branch_resultE),
        .ALU_ResultE(ALU_ResultE), .MemReadE(MemReadE), .RdE(RdE), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .Rs1UsedD(Rs1UsedD), .Rs2UsedD(Rs2UsedD), .imem_ready(imem_ready),
        .PCSel(PCSel), .PCTarget(PCTarget), .PCEn(PCEn), .IFIDEn(IFIDEn),
        .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .misalign_err(misalign_err),
        .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelOutputs();
        bit redir, lu;
        redir = JalE | JalrE | Branch_resultE;
        lu = MemReadE && RdE != 0 && ((Rs1UsedD && Rs1D == RdE) || (Rs2UsedD && Rs2D == RdE));
        expTarget = ALU_ResultE - 32'((JalrE && ALU_ResultE[0]) ? 1 : 0);
        {expSel, expEn, expIfEn, expIfFl, expIdFl} = 5'b00011;
        tookRedir = 0;
        stalled = 0;
        if (rst || holdLeft > 0) begin
        end else if (redir) begin
            {expSel, expEn, expIfEn, expIfFl, expIdFl} = 5'b11011;
            tookRedir = 1;
        end else if (flushLeft > 0) begin
            {expSel, expEn, expIfEn, expIfFl, expIdFl} = {1'b0, imem_ready, 1'b0, 1'b1, 1'b0};
        end else if (waiting) begin
            {expSel, expEn, expIfEn, expIfFl, expIdFl} = {1'b0, imem_ready, imem_ready, !imem_ready, lu};
            stalled = !imem_ready;
        end else if (lu) begin
            {expSel, expEn, expIfEn, expIfFl, expIdFl} = 5'b00001;
            stalled = 1;
        end else if (!imem_ready) begin
            {expSel, expEn, expIfEn, expIfFl, expIdFl} = 5'b00010;
            stalled = 1;
        end else begin
            {expSel, expEn, expIfEn, expIfFl, expIdFl} = 5'b01100;
        end
    endtask

    task automatic modelAdvance();
        if (rst) begin
            holdLeft = 1; flushLeft = 0; waiting = 0;
            redirCount = 0; stallCount = 0; misalign = 0; modelKnown = 1;
        end else if (holdLeft > 0) begin
            holdLeft--;
        end else begin
            if (tookRedir) begin
                flushLeft = FC - 1;
                waiting = 0;
                if (redirCount < CMAX) redirCount++;
                if (expTarget % 4 != 0) misalign = 1;
            end else if (flushLeft > 0) begin
                if (imem_ready) flushLeft--;
            end else if (waiting) begin
                if (imem_ready) waiting = 0;
            end else if (!stalled || !imem_ready) begin
                // A hazard stall keeps RUN; only a memory miss enters the wait.
                if (!imem_ready && !(stalled && expIdFl)) waiting = 1;
            end
            if (stalled && stallCount < CMAX) stallCount++;
        end
    endtask

    task automatic checkOutput(input string tag);
        modelOutputs();
        checkOne({tag, ".PCSel"}, 32'(PCSel), 32'(expSel));
        checkOne({tag, ".PCEn"}, 32'(PCEn), 32'(expEn));
        checkOne({tag, ".IFIDEn"}, 32'(IFIDEn), 32'(expIfEn));
        checkOne({tag, ".IFIDFlush"}, 32'(IFIDFlush), 32'(expIfFl));
        checkOne({tag, ".IDEXFlush"}, 32'(IDEXFlush), 32'(expIdFl));
        checkOne({tag, ".PCTarget"}, PCTarget, expTarget);
        if (modelKnown) begin
            checkOne({tag, ".redirect_cnt"}, 32'(redirect_cnt), 32'(redirCount));
            checkOne({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(stallCount));
            checkOne({tag, ".misalign_err"}, 32'(misalign_err), 32'(misalign));
        end
    endtask

    task automatic applyStimulus(input string tag, input logic r, input logic jal,
                                 input logic jalr, input logic br, input logic [31:0] alu,
                                 input logic memRd, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic rs1U, input logic rs2U,
                                 input logic ready);
        rst = r; JalE = jal; JalrE = jalr; Branch_resultE = br; ALU_ResultE = alu;
        MemReadE = memRd; RdE = rd; Rs1D = rs1; Rs2D = rs2; Rs1UsedD = rs1U; Rs2UsedD = rs2U;
        imem_ready = ready;
        #1;
        checkOutput(tag);
    endtask

    task automatic advance();
        @(posedge clk);
        modelAdvance();
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input logic ready);
        applyStimulus(tag, 0, 0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, ready);
    endtask

    initial begin
        rst = 1; JalE = 0; JalrE = 0; Branch_resultE = 0; ALU_ResultE = 0; MemReadE = 0;
        RdE = 0; Rs1D = 0; Rs2D = 0; Rs1UsedD = 0; Rs2UsedD = 0; imem_ready = 1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            applyStimulus("reset", 1, 0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
            advance();
        end
        idle("hold", 1);
        checkOne("hold.PCEn", 32'(PCEn), 32'd0);
        advance();
        idle("run", 1);
        checkOne("run.PCEn", 32'(PCEn), 32'd1);
        checkOne("run.PCSel", 32'(PCSel), 32'd0);
        advance();

        applyStimulus("loaduse", 0, 0, 0, 0, 32'h0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1);
        checkOne("loaduse.PCEn", 32'(PCEn), 32'd0);
        checkOne("loaduse.IDEXFlush", 32'(IDEXFlush), 32'd1);
        advance();
        idle("afterLu", 1);
        checkOne("afterLu.stall_cnt", 32'(stall_cnt), 32'd1);
        checkOne("afterLu.PCEn", 32'(PCEn), 32'd1);
        advance();

        applyStimulus("jalr", 0, 0, 1, 0, 32'h101, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        checkOne("jalr.PCSel", 32'(PCSel), 32'd1);
        checkOne("jalr.PCTarget", PCTarget, 32'h100);
        advance();
        idle("jalrFlush", 1);
        checkOne("jalrFlush.IFIDFlush", 32'(IFIDFlush), 32'd1);
        checkOne("jalrFlush.redirect_cnt", 32'(redirect_cnt), 32'd1);
        checkOne("jalrFlush.misalign_err", 32'(misalign_err), 32'd0);
        advance();
        idle("jalrDone", 1);
        checkOne("jalrDone.IFIDFlush", 32'(IFIDFlush), 32'd0);
        advance();

        applyStimulus("brLu", 0, 0, 0, 1, 32'h102, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1);
        checkOne("brLu.PCSel", 32'(PCSel), 32'd1);
        checkOne("brLu.IDEXFlush", 32'(IDEXFlush), 32'd1);
        advance();
        idle("brLuFlush", 1);
        checkOne("brLuFlush.stall_cnt", 32'(stall_cnt), 32'd1);
        checkOne("brLuFlush.misalign_err", 32'(misalign_err), 32'd1);
        advance();

        for (int i = 0; i < 4; i++) begin
            idle("imemWait", 0);
            checkOne("imemWait.PCEn", 32'(PCEn), 32'd0);
            advance();
        end
        applyStimulus("jalWait", 0, 1, 0, 0, 32'h200, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        checkOne("jalWait.PCSel", 32'(PCSel), 32'd1);
        checkOne("jalWait.PCEn", 32'(PCEn), 32'd1);
        advance();
        idle("flushHeld", 0);
        checkOne("flushHeld.stall_cnt", 32'(stall_cnt), 32'd5);
        checkOne("flushHeld.IFIDFlush", 32'(IFIDFlush), 32'd1);
        checkOne("flushHeld.IDEXFlush", 32'(IDEXFlush), 32'd0);
        advance();
        applyStimulus("rstFlush", 1, 0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        advance();
        idle("rstHold", 1);
        checkOne("rstHold.PCEn", 32'(PCEn), 32'd0);
        checkOne("rstHold.redirect_cnt", 32'(redirect_cnt), 32'd0);
        checkOne("rstHold.stall_cnt", 32'(stall_cnt), 32'd0);
        checkOne("rstHold.misalign_err", 32'(misalign_err), 32'd0);
        advance();

        for (int i = 0; i < CMAX + 7; i++) begin
            idle("saturate", 0);
            advance();
        end
        idle("satDone", 1);
        checkOne("satDone.stall_cnt", 32'(stall_cnt), 32'(CMAX));
        advance();

        for (int i = 0; i < 600; i++) begin
            applyStimulus("random", $urandom_range(79) == 0, $urandom_range(11) == 0,
                          $urandom_range(11) == 0, $urandom_range(9) == 0, $urandom,
                          $urandom_range(2) == 0, 5'($urandom_range(3)), 5'($urandom_range(3)),
                          5'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                          $urandom_range(3) != 0);
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
